ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: clock-low inhibit time (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000: maximum wait for any device clock edge (15 ms at 50 MHz).
REQ-003 clk  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 PS2_CLK  in  1  PS/2 clock line as sensed (wired-AND with the device).
REQ-006 PS2_DAT  in  1  PS/2 data line as sensed.
REQ-007 tx_data  in  8  command byte to send to the device.
REQ-008 tx_valid  in  1  request to send tx_data.
REQ-009 tx_ready  out  1  high when idle and able to accept a byte.
REQ-010 ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release the line.
REQ-011 ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release the line.
REQ-012 tx_done  out  1  one-cycle pulse: byte sent and acknowledged.
REQ-013 tx_error  out  1  one-cycle pulse: timeout or missing ack.

Function
REQ-014 The FSM SHALL accept a byte when tx_valid && tx_ready, latch tx_data, compute odd parity (~^tx_data), and leave IDLE on the next cycle.
REQ-015 The block SHALL ignore tx_valid whenever tx_ready=0; the latched byte SHALL NOT change mid-transfer.
REQ-016 The FSM states SHALL be IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK and WAIT_IDLE.
REQ-017 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
REQ-018 After INHIBIT the block SHALL enter START: ps2_dat_oe=1 (start bit 0), with ps2_clk_oe=1 for one further cycle.
REQ-019 START SHALL then release ps2_clk_oe and wait for the first filtered falling edge.
REQ-020 Falling-edge detection SHALL use an 8-sample PS2_CLK filter: low only after 8 consecutive 0 samples, high only after 8 consecutive 1 samples; an edge pulse SHALL occur on the high-to-low filtered transition.
REQ-021 On falling edges 1..8 (state DATA), ps2_dat_oe SHALL be set to ~bit, LSB first, on the cycle after the edge pulse.
REQ-022 On falling edge 9 (state PARITY), ps2_dat_oe SHALL be set to ~parity.
REQ-023 On falling edge 10 (state STOP), ps2_dat_oe SHALL be set to 0 (stop bit 1).
REQ-024 On falling edge 11 (state ACK), PS2_DAT SHALL be sampled on the edge-pulse cycle: 0 = ack, proceed to WAIT_IDLE; 1 = nack, pulse tx_error and go to IDLE.
REQ-025 WAIT_IDLE SHALL wait for filtered clock high and PS2_DAT=1, then pulse tx_done and go to IDLE.
REQ-026 A 20-bit timeout counter SHALL clear on every edge pulse and on state entry, and run in START through WAIT_IDLE.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL release both lines, pulse tx_error and go to IDLE on the same transition.
REQ-028 tx_done and tx_error SHALL never assert in the same cycle.
REQ-029 tx_ready SHALL go high the cycle after the done/error pulse.
REQ-030 In IDLE, both oe outputs SHALL be 0.
REQ-031 The bit counter SHALL be 4 bits and SHALL clear on entry to START.

Reset
REQ-032 Reset values SHALL be: state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, tx_done=0, tx_error=0, filter=8'hFF, filtered clock=1, counters=0.
REQ-033 Reset asserted mid-transfer SHALL release both lines on the next clk edge; the transfer is abandoned and no pulse is issued.
REQ-034 tx_valid coincident with reset SHALL be ignored.

Structure
REQ-035 The shared PS/2 package SHALL hold the FSM state enum, the filter depth (8) and the host command constants (0xED set-LEDs, 0xFF reset, 0xF4 enable).
REQ-036 The clock filter/edge detector SHALL be the sub-module ps2_clk_filter, reusable by the receiver.

Verification
REQ-037 Send 0xED to a device model that acks: observe clock held low 5000 cycles, start 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, then one tx_done pulse and tx_ready=1.
REQ-038 Send 0x01: parity bit 0 driven (ps2_dat_oe=1 during PARITY); device acks; tx_done pulses.
REQ-039 Device never clocks: after START plus TIMEOUT_CYCLES, tx_error pulses once, both oe=0, tx_ready=1.
REQ-040 Device holds PS2_DAT high at edge 11: tx_error pulses and tx_done stays 0.
REQ-041 Reset during DATA bit 4: both oe=0 and tx_ready=1 the next cycle, with no pulses.
REQ-042 tx_valid with 0x55 pulsed during a 0xF4 transfer: only 0xF4 appears on the line, with a single tx_done.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmit FSM states, clock filter depth, host command bytes
// and the odd-parity helper used when a command byte is latched.
package ps2_host_tx_pkg;

    localparam int unsigned FILTER_DEPTH = 8;
    localparam int unsigned TMO_W        = 20;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StData,
        StParity,
        StStop,
        StAck,
        StWaitIdle
    } ps2_tx_state_e;

    // Odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
//   tx_data  : byte to send (client -> transmitter)
//   tx_valid : send request (client -> transmitter)
//   tx_ready : transmitter idle and accepting (transmitter -> client)
//   tx_done  : one-cycle pulse, byte sent and acknowledged
//   tx_error : one-cycle pulse, timeout or missing ack
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (output tx_data, output tx_valid,
                    input tx_ready, input tx_done, input tx_error);
    modport slave  (input tx_data, input tx_valid,
                    output tx_ready, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher and falling-edge detector, shared by host transmit and receive.
//   clk, reset : system clock, synchronous active-high reset
//   ps2_clk    : raw sensed PS/2 clock line
//   clk_filt   : filtered level; changes only after FILTER_DEPTH identical samples
//   fall       : one-cycle pulse in the cycle clk_filt goes high -> low
module ps2_clk_filter
    import ps2_host_tx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    output logic clk_filt,
    output logic fall
);

    logic [FILTER_DEPTH-1:0] shift_q;
    logic                    filt_q;
    logic                    fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            shift_q <= {shift_q[FILTER_DEPTH-2:0], ps2_clk};
            fall_q  <= filt_q && (shift_q == '0);
            if (shift_q == '0) begin
                filt_q <= 1'b0;
            end else if (shift_q == '1) begin
                filt_q <= 1'b1;
            end
        end
    end

    assign clk_filt = filt_q;
    assign fall     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
//   clk, reset             : system clock, synchronous active-high reset
//   PS2_CLK, PS2_DAT       : sensed PS/2 lines (wired-AND with the device)
//   bus                    : command handshake (slave side)
//   ps2_clk_oe, ps2_dat_oe : 1 pulls the corresponding line low, 0 releases it
// Sequence: hold clock low, drive start bit, then follow the device clock, changing data
// after each filtered falling edge; the 11th edge samples the device ack.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PS2_CLK,
    input  logic          PS2_DAT,
    ps2_host_tx_if.slave  bus,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    ps2_tx_state_e      state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               par_q, par_d;
    logic [INH_W-1:0]   inh_q, inh_d;
    logic [3:0]         bit_q, bit_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               clk_filt, fall, tmo_run, ready;

    ps2_clk_filter u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .clk_filt (clk_filt),
        .fall     (fall)
    );

    // Ready is held off during the done/error pulse so it rises the cycle after.
    assign ready   = (state_q == StIdle) && !done_q && !err_q;
    assign tmo_run = state_q inside {StStart, StData, StParity, StStop, StAck, StWaitIdle};

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        inh_d    = inh_q;
        bit_d    = bit_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.tx_valid && ready) begin
                    data_d   = bus.tx_data;
                    par_d    = odd_parity(bus.tx_data);
                    inh_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                inh_d = inh_q + 1'b1;
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    dat_oe_d = 1'b1;
                    bit_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                // Clock stays low for the first START cycle (registered), then released.
                clk_oe_d = 1'b0;
                if (fall) begin
                    dat_oe_d = ~data_q[0];
                    bit_d    = 4'd1;
                    state_d  = StData;
                end
            end
            StData: begin
                if (fall) begin
                    if (bit_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                        state_d  = StParity;
                    end else begin
                        dat_oe_d = ~data_q[bit_q[2:0]];
                        bit_d    = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    dat_oe_d = 1'b0;
                    state_d  = StStop;
                end
            end
            // Stop bit is on the line; the next edge is the ack edge.
            StStop: state_d = StAck;
            StAck: begin
                if (fall) begin
                    if (!PS2_DAT) begin
                        state_d = StWaitIdle;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                if (clk_filt && PS2_DAT) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tmo_run && (tmo_q == TMO_W'(TIMEOUT_CYCLES))) begin
            state_d  = StIdle;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
        end

        if (!tmo_run || fall || (state_d != state_q)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            data_q   <= '0;
            par_q    <= 1'b0;
            inh_q    <= '0;
            bit_q    <= '0;
            tmo_q    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_q    <= par_d;
            inh_q    <= inh_d;
            bit_q    <= bit_d;
            tmo_q    <= tmo_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.tx_ready = ready;
    assign bus.tx_done  = done_q;
    assign bus.tx_error = err_q;
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_dat_oe   = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int unsigned INH = 50;
    localparam int unsigned TMO = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic ps2_clk_oe, ps2_dat_oe;
    logic PS2_CLK, PS2_DAT;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;
    int err_seen = 0;
    int both_seen = 0;

    ps2_host_tx_if bus ();

    // Open-drain lines: either side may pull low.
    assign PS2_CLK = dev_clk & ~ps2_clk_oe;
    assign PS2_DAT = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .bus        (bus),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.tx_done) done_seen <= done_seen + 1;
        if (bus.tx_error) err_seen <= err_seen + 1;
        if (bus.tx_done && bus.tx_error) both_seen <= both_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        while (!bus.tx_ready && w < 2000) begin
            tick();
            w++;
        end
        check("send_ready", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    // Device side of one transfer; abort_at > 0 returns after that falling edge.
    task automatic dev_xfer(input int half, input bit ack, input int abort_at, input bit inject,
                            output logic [10:0] got);
        int n;
        int first_dat;
        got = '0;
        n = 0;
        first_dat = -1;
        while (ps2_clk_oe && n < int'(INH) + 100) begin
            if (ps2_dat_oe && first_dat < 0) first_dat = n;
            n++;
            tick();
        end
        check("inhibit_len", 32'(n), 32'(INH + 1));
        check("start_drive_cycle", 32'(first_dat), 32'(INH));
        tick(16);
        got[0] = PS2_DAT;
        for (int e = 1; e <= 11; e++) begin
            dev_clk = 1'b0;
            if (e == abort_at) begin
                tick(half);
                return;
            end
            if (inject && e == 5) begin
                bus.tx_data  = 8'h55;
                bus.tx_valid = 1'b1;
                tick();
                bus.tx_valid = 1'b0;
                tick(half - 1);
            end else begin
                tick(half);
            end
            dev_clk = 1'b1;
            if (e <= 10) got[e] = PS2_DAT;
            if (e == 10 && ack) dev_dat = 1'b0;
            if (e == 11) dev_dat = 1'b1;
            tick(half);
        end
    endtask

    task automatic full_xfer(input string tag, input logic [7:0] b, input int half);
        logic [10:0] got;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        send(b);
        dev_xfer(half, 1'b1, 0, 1'b0, got);
        tick(20);
        check({tag, "_frame"}, 32'(got), 32'(frame_of(b)));
        check({tag, "_done"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_no_err"}, 32'(err_seen - e0), 32'd0);
        check({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
        check({tag, "_oe"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    endtask

    initial begin
        logic [10:0] got;
        int d0, e0, n, seen;

        // tx_valid coincident with reset must be ignored.
        bus.tx_valid = 1'b1;
        bus.tx_data  = CMD_RESET;
        tick(3);
        reset = 1'b0;
        bus.tx_valid = 1'b0;
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_done", 32'(bus.tx_done), 32'd0);
        check("rst_error", 32'(bus.tx_error), 32'd0);
        tick(10);
        check("valid_in_reset_ignored", 32'(ps2_clk_oe), 32'd0);

        full_xfer("set_leds", CMD_SET_LEDS, 20);
        full_xfer("byte01", 8'h01, 16);
        for (int i = 0; i < 4; i++) begin
            full_xfer("random", 8'($urandom), int'($urandom_range(12, 24)));
        end

        // Nack: device leaves data high at edge 11.
        d0 = done_seen;
        e0 = err_seen;
        send(CMD_RESET);
        dev_xfer(18, 1'b0, 0, 1'b0, got);
        tick(20);
        check("nack_frame", 32'(got), 32'(frame_of(CMD_RESET)));
        check("nack_error", 32'(err_seen - e0), 32'd1);
        check("nack_no_done", 32'(done_seen - d0), 32'd0);
        check("nack_ready", 32'(bus.tx_ready), 32'd1);

        // Device never clocks: error TIMEOUT_CYCLES+1 cycles after START begins.
        e0 = err_seen;
        send(CMD_ENABLE);
        n = 0;
        while (!ps2_dat_oe && n < int'(INH) + 50) begin
            tick();
            n++;
        end
        n = 0;
        while (!bus.tx_error && n < int'(TMO) + 100) begin
            tick();
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TMO + 1));
        check("timeout_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        tick();
        check("timeout_ready", 32'(bus.tx_ready), 32'd1);
        tick(5);
        check("timeout_single_error", 32'(err_seen - e0), 32'd1);

        // Reset during data bit 4.
        d0 = done_seen;
        e0 = err_seen;
        send(8'hA5);
        dev_xfer(20, 1'b1, 4, 1'b0, got);
        reset = 1'b1;
        tick();
        check("midrst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("midrst_ready", 32'(bus.tx_ready), 32'd1);
        reset = 1'b0;
        dev_clk = 1'b1;
        tick(40);
        check("midrst_no_done", 32'(done_seen - d0), 32'd0);
        check("midrst_no_error", 32'(err_seen - e0), 32'd0);

        // A request mid-transfer is ignored.
        full_xfer_inject : begin
            d0 = done_seen;
            send(CMD_ENABLE);
            dev_xfer(20, 1'b1, 0, 1'b1, got);
            tick(20);
            check("inject_frame", 32'(got), 32'(frame_of(CMD_ENABLE)));
            check("inject_done", 32'(done_seen - d0), 32'd1);
            seen = 0;
            for (int i = 0; i < 80; i++) begin
                if (ps2_clk_oe) seen++;
                tick();
            end
            check("inject_no_second", 32'(seen), 32'd0);
        end

        check("never_done_and_error", 32'(both_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
